// File: rtl/common_params.sv
// Shared word/address widths and the memory controller state type.
package common_params;
    localparam int REG_W  = 64;
    localparam int ADDR_W = 32;
    localparam int LANES  = REG_W / 8;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} mem_state_e;

    // Byte-lane merge: lanes with be[k] take new_w, the rest keep old_w.
    function automatic logic [REG_W-1:0] lane_merge(logic [REG_W-1:0] old_w,
                                                    logic [REG_W-1:0] new_w,
                                                    logic [LANES-1:0] be);
        logic [REG_W-1:0] res;
        res = old_w;
        for (int k = 0; k < LANES; k++)
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        return res;
    endfunction
endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between a load/store unit and data_memory.
interface data_memory_if;
    import common_params::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [REG_W-1:0]  st_data;
    logic [7:0]        we;
    logic              re;
    logic [REG_W-1:0]  ld_data;
    logic              ld_valid;
    logic              ready;

    modport master (output mem_addr, st_data, we, re,
                    input  ld_data, ld_valid, ready);
    modport slave  (input  mem_addr, st_data, we, re,
                    output ld_data, ld_valid, ready);
endinterface

// File: rtl/mem_read_pipe.sv
// Read-return delay line: stage 0 captures the array word, stage STAGES drives the output.
module mem_read_pipe
    import common_params::*;
#(
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    input  logic [REG_W-1:0] in_data,
    output logic             out_vld,
    output logic [REG_W-1:0] out_data
);
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][REG_W-1:0] data_pipe;
    logic [STAGES:0]            vld_in;
    logic [STAGES:0][REG_W-1:0] data_in;

    always_comb begin
        vld_in     = '0;
        data_in    = '0;
        vld_in[0]  = in_vld;
        data_in[0] = in_data;
        for (int k = 1; k <= STAGES; k++) begin
            vld_in[k]  = vld_pipe[k-1];
            data_in[k] = data_pipe[k-1];
        end
    end

    // The last stage only loads on a valid beat so ld_data holds between returns.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe <= vld_in;
            for (int k = 0; k < STAGES; k++)
                data_pipe[k] <= data_in[k];
            if (vld_in[STAGES])
                data_pipe[STAGES] <= data_in[STAGES];
        end
    end

    assign out_vld  = vld_pipe[STAGES];
    assign out_data = data_pipe[STAGES];
endmodule

// File: rtl/data_memory.sv
// Byte-lane-writable word memory with a power-up clear sweep and a pipelined read return.
module data_memory
    import common_params::*;
#(
    parameter int LOAD_LATENCY = 1,
    parameter int DEPTH_LOG2   = 12
) (
    input logic          clk,
    input logic          rst,
    data_memory_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    mem_state_e            state_q, state_d;
    logic [DEPTH_LOG2-1:0] clr_cnt_q, clr_cnt_d;
    logic [REG_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  ready;
    logic                  rd_acc;
    logic                  unused_addr_hi;

    // Address wraps: only the low DEPTH_LOG2 bits select a word.
    assign idx            = bus.mem_addr[DEPTH_LOG2-1:0];
    assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = CLEAR;
        endcase
    end

    assign ready     = (state_q == RUN);
    assign bus.ready = ready;
    assign rd_acc    = bus.re & ready & ~rst;

    // Reads sample mem[idx] before this edge's write lands: read-before-write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR)
                mem[clr_cnt_q] <= '0;
            else if (|bus.we)
                mem[idx] <= lane_merge(mem[idx], bus.st_data, bus.we);
        end
    end

    mem_read_pipe #(.STAGES(LOAD_LATENCY - 1)) u_read_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (rd_acc),
        .in_data  (mem[idx]),
        .out_vld  (bus.ld_valid),
        .out_data (bus.ld_data)
    );
endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed checks of data_memory against a word-array/queue reference model.
module tb_data_memory;
    import common_params::*;

    localparam int LL    = 3;
    localparam int DL2   = 4;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_if bus();

    data_memory #(.LOAD_LATENCY(LL), .DEPTH_LOG2(DL2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain word array, cycles-left-in-clear count, queue of due reads.
    typedef struct {
        longint      due;
        logic [63:0] data;
    } rd_t;

    logic [63:0] ref_mem [DEPTH];
    rd_t         pend[$];
    int          clear_left = DEPTH;
    longint      edge_n     = 0;
    logic        exp_vld    = 1'b0;
    logic [63:0] exp_data   = '0;

    task automatic model_edge();
        int w;
        edge_n++;
        exp_vld = 1'b0;
        if (rst) begin
            clear_left = DEPTH;
            pend.delete();
            exp_data = '0;
            foreach (ref_mem[i]) ref_mem[i] = '0;
            return;
        end
        if (clear_left > 0) begin
            clear_left--;
        end else begin
            w = int'(bus.mem_addr % DEPTH);
            if (bus.re) pend.push_back('{edge_n + LL - 1, ref_mem[w]});
            for (int k = 0; k < 8; k++)
                if (bus.we[k]) ref_mem[w][8*k +: 8] = bus.st_data[8*k +: 8];
        end
        if (pend.size() > 0 && pend[0].due == edge_n) begin
            exp_vld  = 1'b1;
            exp_data = pend[0].data;
            void'(pend.pop_front());
        end
    endtask

    task automatic step(logic [31:0] a, logic [63:0] d, logic [7:0] be, logic r, logic rs);
        bus.mem_addr = a;
        bus.st_data  = d;
        bus.we       = be;
        bus.re       = r;
        rst          = rs;
        @(posedge clk);
        model_edge();
        #1;
        chk("ready",    64'(bus.ready),    64'(clear_left == 0));
        chk("ld_valid", 64'(bus.ld_valid), 64'(exp_vld));
        chk("ld_data",  bus.ld_data,       exp_data);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(32'd0, 64'd0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic rand_step(logic allow_rst);
        logic [7:0] be;
        be = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
        step(32'($urandom_range(0, 2*DEPTH-1)), {$urandom, $urandom}, be,
             1'($urandom_range(0, 1)), allow_rst && ($urandom_range(0, 199) == 0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.mem_addr = '0;
        bus.st_data  = '0;
        bus.we       = '0;
        bus.re       = 1'b0;

        // Reset, then a clear sweep with ignored random traffic.
        step(32'd0, 64'd0, 8'h00, 1'b0, 1'b1);
        chk("rst_ld_data", bus.ld_data, 64'd0);
        for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
        chk("ready_after_sweep", 64'(bus.ready), 64'd1);
        for (int i = 0; i < DEPTH; i++) step(32'(i), 64'd0, 8'h00, 1'b1, 1'b0);
        idle(LL);

        // Full write then single-lane patch.
        step(32'd3, 64'h1122334455667788, 8'hff, 1'b0, 1'b0);
        step(32'd3, 64'h00000000000000AA, 8'h01, 1'b0, 1'b0);
        step(32'd3, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(LL - 1);
        chk("lane_patch", bus.ld_data, 64'h11223344556677AA);
        idle(2);

        // Back-to-back reads return in order on consecutive cycles.
        step(32'd0, 64'hA0, 8'hff, 1'b0, 1'b0);
        step(32'd1, 64'hA1, 8'hff, 1'b0, 1'b0);
        step(32'd2, 64'hA2, 8'hff, 1'b0, 1'b0);
        step(32'd0, 64'd0, 8'h00, 1'b1, 1'b0);
        step(32'd1, 64'd0, 8'h00, 1'b1, 1'b0);
        chk("burst_early", 64'(bus.ld_valid), 64'd0);
        step(32'd2, 64'd0, 8'h00, 1'b1, 1'b0);
        chk("burst_v0", 64'(bus.ld_valid), 64'd1);
        chk("burst_d0", bus.ld_data, 64'hA0);
        idle(1);
        chk("burst_d1", bus.ld_data, 64'hA1);
        idle(1);
        chk("burst_d2", bus.ld_data, 64'hA2);
        idle(1);
        chk("burst_end", 64'(bus.ld_valid), 64'd0);
        chk("burst_hold", bus.ld_data, 64'hA2);

        // Same-cycle read and write: old data, then new.
        step(32'd7, 64'h9, 8'hff, 1'b0, 1'b0);
        step(32'd7, 64'h5, 8'hff, 1'b1, 1'b0);
        step(32'd7, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(LL - 2);
        chk("rbw_old", bus.ld_data, 64'h9);
        idle(1);
        chk("rbw_new", bus.ld_data, 64'h5);

        // Address wrap: word DEPTH+2 aliases word 2.
        step(32'(DEPTH + 2), 64'hCAFE, 8'hff, 1'b0, 1'b0);
        step(32'd2, 64'd0, 8'h00, 1'b1, 1'b0);
        idle(LL - 1);
        chk("wrap", bus.ld_data, 64'hCAFE);

        // Reset with two reads in flight.
        step(32'd1, 64'd0, 8'h00, 1'b1, 1'b0);
        step(32'd2, 64'd0, 8'h00, 1'b1, 1'b0);
        step(32'd0, 64'd0, 8'h00, 1'b0, 1'b1);
        chk("flight_rst_data", bus.ld_data, 64'd0);
        for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
        chk("flight_rst_ready", 64'(bus.ready), 64'd1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) rand_step(1'b1);
        idle(LL + DEPTH);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
